// File: rtl/fcfs_arb_pkg.sv
// Shared types and helpers for the FCFS arbiter: state enum plus index/mask
// utilities used by the arbiter and its ID queue.
package fcfs_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  function automatic logic [31:0] onehot_from_index(input int idx);
    return 32'h1 << idx;
  endfunction

  // Bits strictly below idx; lets each pushed ID find its slot offset directly.
  function automatic logic [31:0] mask_below_index(input int idx);
    return (32'h1 << idx) - 32'h1;
  endfunction

  function automatic int popcount32(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/fcfs_id_fifo.sv
// Circular ID queue: several requester IDs pushed per edge (lowest index at the
// tail first), one popped per edge, with an occupancy count.
module fcfs_id_fifo
  import fcfs_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [DEPTH-1:0]           push,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    slot [DEPTH];
  logic [31:0]      push_ext;
  int               npush;

  function automatic logic [PW-1:0] wrap(input int v);
    return (v >= DEPTH) ? PW'(v - DEPTH) : PW'(v);
  endfunction

  always_comb begin
    push_ext = 32'(push);
    npush    = popcount32(push_ext);
    for (int i = 0; i < DEPTH; i++) begin
      slot[i] = wrap(int'(wr_ptr) + popcount32(push_ext & mask_below_index(i)));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push[i]) mem[slot[i]] <= WIDTH'(i);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wrap(int'(wr_ptr) + npush);
      if (pop) rd_ptr <= wrap(int'(rd_ptr) + 1);
      count  <= CW'(int'(count) + npush - (pop ? 1 : 0));
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fcfs_arbiter_n.sv
// First-come-first-served arbiter with per-tenure burst limit and one-hot grant.
// Define FCFS_LOCK_EN to add a lock input that suppresses burst expiry.
module fcfs_arbiter_n
  import fcfs_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4,
  parameter int IDW       = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_REQ-1:0]           req,
`ifdef FCFS_LOCK_EN
  input  logic                         lock,
`endif
  output logic [NUM_REQ-1:0]           grant,
  output logic                         grant_valid,
  output logic [IDW-1:0]               grant_id,
  output logic [$clog2(NUM_REQ+1)-1:0] queue_cnt
);

  localparam int BW = $clog2(BURST_LEN+1);

  arb_state_t         state, state_nxt;
  logic [NUM_REQ-1:0] queued;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] head_mask;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [IDW-1:0]     grant_id_nxt;
  logic [IDW-1:0]     head;
  logic [BW-1:0]      burst_cnt, burst_nxt;
  logic               tenure_end;
  logic               pop;
  logic               lock_hold;

`ifdef FCFS_LOCK_EN
  assign lock_hold = grant_valid & lock;
`else
  assign lock_hold = 1'b0;
`endif

  fcfs_id_fifo #(
    .DEPTH (NUM_REQ),
    .WIDTH (IDW)
  ) u_id_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .head   (head),
    .count  (queue_cnt)
  );

  assign grant_valid = |grant;
  assign head_mask   = NUM_REQ'(onehot_from_index(int'(head)));

  // A popped head whose request has gone away is simply discarded.
  always_comb begin
    push         = req & ~queued & ~grant;
    tenure_end   = (state == ARB_GRANT) &&
                   (!req[grant_id] ||
                    ((burst_cnt == BW'(BURST_LEN)) && (queue_cnt != '0) && !lock_hold));
    pop          = ((state == ARB_IDLE) || tenure_end) && (queue_cnt != '0);
    state_nxt    = state;
    grant_nxt    = grant;
    grant_id_nxt = grant_id;
    burst_nxt    = burst_cnt;
    if ((state == ARB_IDLE) || tenure_end) begin
      state_nxt    = ARB_IDLE;
      grant_nxt    = '0;
      grant_id_nxt = '0;
      burst_nxt    = '0;
      if (pop && req[head]) begin
        state_nxt    = ARB_GRANT;
        grant_nxt    = head_mask;
        grant_id_nxt = head;
        burst_nxt    = BW'(1);
      end
    end else if (burst_cnt != BW'(BURST_LEN)) begin
      burst_nxt = burst_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      grant_id  <= '0;
      burst_cnt <= '0;
      queued    <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      grant_id  <= grant_id_nxt;
      burst_cnt <= burst_nxt;
      queued    <= (queued | push) & ~(pop ? head_mask : '0);
    end
  end

endmodule

// File: tb/tb_fcfs_arbiter_n.sv
// Directed bench for fcfs_arbiter_n (NUM_REQ=4, BURST_LEN=4); hand-derived
// per-edge expectations flow through a scoreboard queue.
module tb_fcfs_arbiter_n;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] req = 4'b0000;
`ifdef FCFS_LOCK_EN
  logic       lock = 1'b0;
`endif
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [2:0] queue_cnt;

  typedef struct packed {
    logic [3:0] grant;
    logic [2:0] qcnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  fcfs_arbiter_n #(
    .NUM_REQ   (4),
    .BURST_LEN (4)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req         (req),
`ifdef FCFS_LOCK_EN
    .lock        (lock),
`endif
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .queue_cnt   (queue_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] id_of(input logic [3:0] g);
    logic [1:0] id;
    id = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) id = 2'(i);
    end
    return id;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expd);
    end
  endtask

  task automatic check_output(input string tag);
    exp_t e;
    e = sb.pop_front();
    check_val({tag, " grant"},       32'(grant),       32'(e.grant));
    check_val({tag, " grant_valid"}, 32'(grant_valid), 32'(|e.grant));
    check_val({tag, " grant_id"},    32'(grant_id),    32'(id_of(e.grant)));
    check_val({tag, " queue_cnt"},   32'(queue_cnt),   32'(e.qcnt));
  endtask

  task automatic push_exp(input logic [3:0] g, input logic [2:0] q);
    exp_t e;
    e.grant = g;
    e.qcnt  = q;
    sb.push_back(e);
  endtask

  // Drive req, then check the outputs produced by the edge that sampled it.
  task automatic apply_stimulus(input string tag, input logic [3:0] r,
                                input logic [3:0] g, input logic [2:0] q);
    req = r;
    push_exp(g, q);
    @(posedge clk);
    #1;
    check_output(tag);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1;
    push_exp(4'b0000, 3'd0);
    check_output("reset");
    #12;
    resetn = 1'b1;

    // Arrival order 2,0,3 with back-to-back handoffs
    apply_stimulus("t1 e0", 4'b0100, 4'b0000, 3'd1);
    apply_stimulus("t1 e1", 4'b0101, 4'b0100, 3'd1);
    apply_stimulus("t1 e2", 4'b1001, 4'b0001, 3'd1);
    apply_stimulus("t1 e3", 4'b1000, 4'b1000, 3'd0);
    apply_stimulus("t1 e4", 4'b0000, 4'b0000, 3'd0);

    // Simultaneous arrival: lower index wins
    apply_stimulus("t2 e0", 4'b1010, 4'b0000, 3'd2);
    apply_stimulus("t2 e1", 4'b1010, 4'b0010, 3'd1);
    apply_stimulus("t2 e2", 4'b1010, 4'b0010, 3'd1);
    apply_stimulus("t2 e3", 4'b1000, 4'b1000, 3'd0);
    apply_stimulus("t2 e4", 4'b1000, 4'b1000, 3'd0);
    apply_stimulus("t2 e5", 4'b0000, 4'b0000, 3'd0);

    // Burst rotation between two continuous requesters
    apply_stimulus("t3 e0", 4'b0001, 4'b0000, 3'd1);
    for (int t = 0; t < 4; t++) begin
      for (int c = 0; c < 4; c++) begin
        apply_stimulus($sformatf("t3 ten%0d c%0d", t, c), 4'b0011,
                       (t % 2 == 0) ? 4'b0001 : 4'b0010,
                       (t == 0 || c != 0) ? 3'd1 : 3'd0);
      end
    end
    apply_stimulus("t3 drop", 4'b0000, 4'b0000, 3'd0);
    apply_stimulus("t3 idle", 4'b0000, 4'b0000, 3'd0);

    // Lone requester keeps the grant past the burst limit
    apply_stimulus("t4 e0", 4'b0100, 4'b0000, 3'd1);
    for (int c = 1; c < 10; c++) begin
      apply_stimulus($sformatf("t4 e%0d", c), 4'b0100, 4'b0100, 3'd0);
    end
    apply_stimulus("t4 drop", 4'b0000, 4'b0000, 3'd0);

    // Withdrawn request is purged without a grant pulse
    apply_stimulus("t5 e0", 4'b0001, 4'b0000, 3'd1);
    apply_stimulus("t5 e1", 4'b0001, 4'b0001, 3'd0);
    apply_stimulus("t5 e2", 4'b0011, 4'b0001, 3'd1);
    apply_stimulus("t5 e3", 4'b0001, 4'b0001, 3'd1);
    apply_stimulus("t5 e4", 4'b0000, 4'b0000, 3'd0);
    apply_stimulus("t5 e5", 4'b0000, 4'b0000, 3'd0);

    // Asynchronous reset in the middle of a tenure
    apply_stimulus("t6 e0", 4'b0111, 4'b0000, 3'd3);
    apply_stimulus("t6 e1", 4'b0111, 4'b0001, 3'd2);
    #3;
    resetn = 1'b0;
    #1;
    push_exp(4'b0000, 3'd0);
    check_output("t6 async");
    req = 4'b0000;
    #2;
    resetn = 1'b1;
    apply_stimulus("t6 post0", 4'b0000, 4'b0000, 3'd0);
    apply_stimulus("t6 post1", 4'b0000, 4'b0000, 3'd0);
    apply_stimulus("t6 post2", 4'b0000, 4'b0000, 3'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
